ammon_lc3_cpu: RTL and testbench

Multi-cycle LC-3 processor core: fetches, decodes and executes the full LC-3 base instruction set against a single external word-addressed memory port. It sits under the system top level, connected to the bench-side memory/test interface. The bench preloads a program, releases reset and checks register, memory and PC effects.

---
 rtl/ammon_lc3_cpu.sv | 236 +++++++++++++++++++++++
 tb/tb_ammon_lc3_cpu.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ammon_lc3_cpu.sv
// ammon_lc3_cpu: multi-cycle LC-3 core with one word-addressed memory port.
// Every instruction walks FETCH -> DECODE -> EXEC, and memory instructions
// add INDIRECT and/or MEM_WB. The memory port is fully registered. Read data
// is taken combinationally from the registered address in the cycle that
// follows the strobe edge.
module ammon_lc3_cpu #(
    parameter int ADDRESS_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [15:0]              mem_wdata,
    output logic                     mem_we,
    output logic                     mem_re,
    input  logic [15:0]              mem_rdata,
    output logic [15:0]              pc,
    output logic [15:0]              ir
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_INDIRECT,
        S_MEM_WB
    } state_e;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    // Condition codes are held one-hot as {N, Z, P}.
    localparam logic [2:0] CC_Z = 3'b010;

    state_e             state_q, state_d;
    logic [15:0]        pc_q, pc_d;
    logic [15:0]        ir_q, ir_d;
    logic [2:0]         cc_q, cc_d;
    logic [7:0][15:0]   regs_q;
    logic [15:0]        addr_q, addr_d;
    logic [15:0]        wdata_q, wdata_d;
    logic               re_q, re_d;
    logic               we_q, we_d;

    logic               rf_we;
    logic [2:0]         rf_waddr;
    logic [15:0]        rf_wdata;

    // Instruction fields and operand values
    logic [3:0]  op;
    logic [2:0]  dr, sr1, sr2;
    logic [15:0] sext5, sext6, sext9, sext11;
    logic [15:0] sr1_val, sr2_val, dr_val, opnd2;
    logic [15:0] pc_off9, base_off6;

    assign op        = ir_q[15:12];
    assign dr        = ir_q[11:9];
    assign sr1       = ir_q[8:6];
    assign sr2       = ir_q[2:0];
    assign sext5     = {{11{ir_q[4]}}, ir_q[4:0]};
    assign sext6     = {{10{ir_q[5]}}, ir_q[5:0]};
    assign sext9     = {{7{ir_q[8]}}, ir_q[8:0]};
    assign sext11    = {{5{ir_q[10]}}, ir_q[10:0]};
    assign sr1_val   = regs_q[sr1];
    assign sr2_val   = regs_q[sr2];
    // Store source register shares the DR field position.
    assign dr_val    = regs_q[dr];
    assign opnd2     = ir_q[5] ? sext5 : sr2_val;
    // pc_q is already incremented by the time EXEC runs.
    assign pc_off9   = pc_q + sext9;
    assign base_off6 = sr1_val + sext6;

    assign mem_addr  = addr_q[ADDRESS_WIDTH-1:0];
    assign mem_wdata = wdata_q;
    assign mem_we    = we_q;
    assign mem_re    = re_q;
    assign pc        = pc_q;
    assign ir        = ir_q;

    function automatic logic [2:0] cc_of(input logic [15:0] v);
        if (v[15])
            return 3'b100;
        else if (v == 16'h0000)
            return 3'b010;
        else
            return 3'b001;
    endfunction

    // Next-state, memory strobes and register writeback for the current state
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        cc_d     = cc_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        re_d     = 1'b0;
        we_d     = 1'b0;
        rf_we    = 1'b0;
        rf_waddr = dr;
        rf_wdata = 16'h0000;
        case (state_q)
            S_FETCH: begin
                addr_d  = pc_q;
                re_d    = 1'b1;
                pc_d    = pc_q + 16'd1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ir_d    = mem_rdata;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (op)
                    OP_ADD, OP_AND, OP_NOT: begin
                        rf_we = 1'b1;
                        if (op == OP_ADD)
                            rf_wdata = sr1_val + opnd2;
                        else if (op == OP_AND)
                            rf_wdata = sr1_val & opnd2;
                        else
                            rf_wdata = ~sr1_val;
                        cc_d = cc_of(rf_wdata);
                    end
                    OP_BR: begin
                        if ((ir_q[11:9] & cc_q) != 3'b000)
                            pc_d = pc_off9;
                    end
                    OP_JMP: pc_d = sr1_val;
                    OP_JSR: begin
                        // Target uses the old R7 when BaseR is R7; the
                        // link write lands on the same edge.
                        pc_d     = ir_q[11] ? (pc_q + sext11) : sr1_val;
                        rf_we    = 1'b1;
                        rf_waddr = 3'd7;
                        rf_wdata = pc_q;
                    end
                    OP_LEA: begin
                        rf_we    = 1'b1;
                        rf_wdata = pc_off9;
                    end
                    OP_LD, OP_LDR: begin
                        addr_d  = (op == OP_LDR) ? base_off6 : pc_off9;
                        re_d    = 1'b1;
                        state_d = S_MEM_WB;
                    end
                    OP_LDI, OP_STI: begin
                        addr_d  = pc_off9;
                        re_d    = 1'b1;
                        state_d = S_INDIRECT;
                    end
                    OP_ST, OP_STR: begin
                        addr_d  = (op == OP_STR) ? base_off6 : pc_off9;
                        wdata_d = dr_val;
                        we_d    = 1'b1;
                    end
                    OP_TRAP: begin
                        rf_we    = 1'b1;
                        rf_waddr = 3'd7;
                        rf_wdata = pc_q;
                        addr_d   = {8'h00, ir_q[7:0]};
                        re_d     = 1'b1;
                        state_d  = S_MEM_WB;
                    end
                    default: ;
                endcase
            end
            S_INDIRECT: begin
                addr_d = mem_rdata;
                if (op == OP_LDI) begin
                    re_d    = 1'b1;
                    state_d = S_MEM_WB;
                end else begin
                    wdata_d = dr_val;
                    we_d    = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEM_WB: begin
                state_d = S_FETCH;
                if (op == OP_TRAP) begin
                    pc_d = mem_rdata;
                end else begin
                    rf_we    = 1'b1;
                    rf_wdata = mem_rdata;
                    cc_d     = cc_of(mem_rdata);
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Architectural and bus state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            pc_q    <= 16'h3000;
            ir_q    <= 16'h0000;
            cc_q    <= CC_Z;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cc_q    <= cc_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            re_q    <= re_d;
            we_q    <= we_d;
        end
    end

    // General-purpose register file, single write port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            regs_q <= '0;
        else if (rf_we)
            regs_q[rf_waddr] <= rf_wdata;
    end

endmodule

// File: tb/tb_ammon_lc3_cpu.sv
// Bench for ammon_lc3_cpu: an instruction-level LC-3 model predicts the
// per-cycle bus activity and the register/PC/CC state after each instruction.
module tb_ammon_lc3_cpu;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] mem_rdata;
    logic [15:0] pc;
    logic [15:0] ir;

    always #5 clk = ~clk;

    // Bench memory: combinational read of the registered address.
    logic [15:0] mem [0:65535];
    assign mem_rdata = mem[mem_addr];

    ammon_lc3_cpu #(.ADDRESS_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .pc(pc), .ir(ir)
    );

    int checks = 0;
    int errors = 0;

    // Instruction-level model state
    logic [15:0] m_reg [0:7];
    logic [15:0] m_pc;
    logic [2:0]  m_cc;
    logic [15:0] m_mem [0:65535];

    // Expected bus activity for cycles 1..5 of the current instruction
    logic        t_re [1:5];
    logic        t_we [1:5];
    logic [15:0] t_addr [1:5];
    logic [15:0] t_wd [1:5];

    logic        st_pend = 1'b0;
    logic [15:0] st_addr, st_val;

    logic        b_we = 1'b0;
    logic [15:0] b_addr, b_wd;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // One clock: the store seen on the bus last cycle lands in memory.
    task automatic tick();
        @(posedge clk);
        #1;
        if (b_we) mem[b_addr] = b_wd;
        b_we   = mem_we;
        b_addr = mem_addr;
        b_wd   = mem_wdata;
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] v);
        mem[a]   = v;
        m_mem[a] = v;
    endtask

    task automatic m_wr(input logic [2:0] d, input logic [15:0] v);
        m_reg[d] = v;
        m_cc = v[15] ? 3'b100 : (v == 16'h0) ? 3'b010 : 3'b001;
    endtask

    task automatic m_store(input logic [15:0] a, input logic [15:0] v);
        m_mem[a] = v;
        st_pend  = 1'b1;
        st_addr  = a;
        st_val   = v;
    endtask

    // Execute one instruction in the model; returns its clock count.
    task automatic m_step(output int L, output logic [15:0] ins, output logic [15:0] pc0);
        logic [15:0] s5, s6, s9, s11, ea, ptr, t;
        logic [2:0]  d, s1, s2;
        for (int j = 1; j <= 5; j++) begin
            t_re[j] = 1'b0; t_we[j] = 1'b0; t_addr[j] = 16'h0; t_wd[j] = 16'h0;
        end
        pc0  = m_pc;
        ins  = m_mem[m_pc];
        m_pc = m_pc + 16'd1;
        t_re[1] = 1'b1; t_addr[1] = pc0;
        L   = 3;
        d   = ins[11:9]; s1 = ins[8:6]; s2 = ins[2:0];
        s5  = {{11{ins[4]}}, ins[4:0]};
        s6  = {{10{ins[5]}}, ins[5:0]};
        s9  = {{7{ins[8]}}, ins[8:0]};
        s11 = {{5{ins[10]}}, ins[10:0]};
        case (ins[15:12])
            4'h1: m_wr(d, m_reg[s1] + (ins[5] ? s5 : m_reg[s2]));
            4'h5: m_wr(d, m_reg[s1] & (ins[5] ? s5 : m_reg[s2]));
            4'h9: m_wr(d, ~m_reg[s1]);
            4'h0: if ((ins[11:9] & m_cc) != 3'b000) m_pc = m_pc + s9;
            4'hC: m_pc = m_reg[s1];
            4'h4: begin
                t = m_pc;
                m_pc = ins[11] ? m_pc + s11 : m_reg[s1];
                m_reg[7] = t;
            end
            4'hE: m_reg[d] = m_pc + s9;
            4'h2, 4'h6: begin
                ea = (ins[15:12] == 4'h6) ? m_reg[s1] + s6 : m_pc + s9;
                t_re[3] = 1'b1; t_addr[3] = ea;
                m_wr(d, m_mem[ea]);
                L = 4;
            end
            4'hA: begin
                ea = m_pc + s9; ptr = m_mem[ea];
                t_re[3] = 1'b1; t_addr[3] = ea;
                t_re[4] = 1'b1; t_addr[4] = ptr;
                m_wr(d, m_mem[ptr]);
                L = 5;
            end
            4'h3, 4'h7: begin
                ea = (ins[15:12] == 4'h7) ? m_reg[s1] + s6 : m_pc + s9;
                t_we[3] = 1'b1; t_addr[3] = ea; t_wd[3] = m_reg[d];
                m_store(ea, m_reg[d]);
            end
            4'hB: begin
                ea = m_pc + s9; ptr = m_mem[ea];
                t_re[3] = 1'b1; t_addr[3] = ea;
                t_we[4] = 1'b1; t_addr[4] = ptr; t_wd[4] = m_reg[d];
                m_store(ptr, m_reg[d]);
                L = 4;
            end
            4'hF: begin
                m_reg[7] = m_pc;
                t_re[3] = 1'b1; t_addr[3] = {8'h00, ins[7:0]};
                m_pc = m_mem[{8'h00, ins[7:0]}];
                L = 4;
            end
            default: ;
        endcase
    endtask

    // Run n instructions, comparing the DUT every cycle against the model.
    task automatic run(input int n);
        int L;
        logic [15:0] ins, pc0, p_addr, p_val;
        logic p_pend;
        for (int k = 0; k < n; k++) begin
            p_pend = st_pend; p_addr = st_addr; p_val = st_val;
            st_pend = 1'b0;
            m_step(L, ins, pc0);
            for (int j = 1; j <= L; j++) begin
                tick();
                if (j == 1 && p_pend)
                    chk($sformatf("store_data @%h", p_addr), mem[p_addr], p_val);
                chk($sformatf("mem_re pc%h c%0d", pc0, j), {15'h0, mem_re}, {15'h0, t_re[j]});
                chk($sformatf("mem_we pc%h c%0d", pc0, j), {15'h0, mem_we}, {15'h0, t_we[j]});
                if (t_re[j] || t_we[j])
                    chk($sformatf("mem_addr pc%h c%0d", pc0, j), mem_addr, t_addr[j]);
                if (t_we[j])
                    chk($sformatf("mem_wdata pc%h c%0d", pc0, j), mem_wdata, t_wd[j]);
                if (j == 1)
                    chk($sformatf("pc_inc pc%h", pc0), pc, pc0 + 16'd1);
                if (j == 2)
                    chk($sformatf("ir pc%h", pc0), ir, ins);
                if (j == L) begin
                    for (int r = 0; r < 8; r++)
                        chk($sformatf("R%0d after %h@%h", r, ins, pc0), dut.regs_q[r], m_reg[r]);
                    chk($sformatf("cc after %h@%h", ins, pc0), {13'h0, dut.cc_q}, {13'h0, m_cc});
                    chk($sformatf("pc after %h@%h", ins, pc0), pc, m_pc);
                end
            end
        end
    endtask

    // Let any last store commit, then hold the core in reset and check reset values.
    task automatic hold_reset();
        tick();
        if (st_pend) chk($sformatf("store_data @%h", st_addr), mem[st_addr], st_val);
        st_pend = 1'b0;
        reset = 1'b0;
        #1;
        b_we = 1'b0;
        chk("rst pc", pc, 16'h3000);
        chk("rst ir", ir, 16'h0000);
        chk("rst mem_re", {15'h0, mem_re}, 16'h0);
        chk("rst mem_we", {15'h0, mem_we}, 16'h0);
        chk("rst mem_addr", mem_addr, 16'h0000);
        chk("rst mem_wdata", mem_wdata, 16'h0000);
        chk("rst cc", {13'h0, dut.cc_q}, 16'h0002);
        for (int r = 0; r < 8; r++)
            chk($sformatf("rst R%0d", r), dut.regs_q[r], 16'h0000);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int r = 0; r < 8; r++) m_reg[r] = 16'h0;
        m_pc = 16'h3000;
        m_cc = 3'b010;
    endtask

    task automatic fill_random();
        for (int a = 0; a < 65536; a++) begin
            mem[a]   = 16'($urandom);
            m_mem[a] = mem[a];
        end
    endtask

    initial begin
        fill_random();

        // AND R0,R0,#0 ; ADD R0,R0,#5
        hold_reset();
        poke(16'h3000, 16'h5020); poke(16'h3001, 16'h1025);
        release_reset();
        run(2);
        chk("t1 R0", dut.regs_q[0], 16'h0005);
        chk("t1 R0 model", m_reg[0], 16'h0005);
        chk("t1 cc", {13'h0, dut.cc_q}, 16'h0001);
        chk("t1 pc", pc, 16'h3002);

        // LD R0,+2 from 0x3003
        hold_reset();
        poke(16'h3000, 16'h2002); poke(16'h3003, 16'h8000);
        release_reset();
        run(1);
        chk("t2 R0", dut.regs_q[0], 16'h8000);
        chk("t2 cc", {13'h0, dut.cc_q}, 16'h0004);
        chk("t2 ea model", t_addr[3], 16'h3003);

        // LD R1 ; STI R1 via pointer 0x4000 ; LDI R2 via same pointer
        hold_reset();
        poke(16'h3000, 16'h2204); poke(16'h3001, 16'hB202);
        poke(16'h3002, 16'hA401); poke(16'h3003, 16'h0000);
        poke(16'h3004, 16'h4000); poke(16'h3005, 16'h1234);
        release_reset();
        run(3);
        chk("t3 mem4000", mem[16'h4000], 16'h1234);
        chk("t3 R2", dut.regs_q[2], 16'h1234);
        chk("t3 R2 model", m_reg[2], 16'h1234);

        // BRz -1 loops on itself once Z is set
        hold_reset();
        poke(16'h3000, 16'h5020); poke(16'h3001, 16'h05FF);
        release_reset();
        run(4);
        chk("t4 pc loop", pc, 16'h3001);

        // BRp with CC=Z falls through
        hold_reset();
        poke(16'h3000, 16'h5020); poke(16'h3001, 16'h03FF);
        release_reset();
        run(2);
        chk("t5 pc fall", pc, 16'h3002);

        // JSR +0x10 then RET
        hold_reset();
        poke(16'h3000, 16'h4810); poke(16'h3011, 16'hC1C0);
        release_reset();
        run(1);
        chk("t6 R7", dut.regs_q[7], 16'h3001);
        chk("t6 pc jsr", pc, 16'h3011);
        run(1);
        chk("t6 pc ret", pc, 16'h3001);

        // TRAP x25 through vector 0x5000
        hold_reset();
        poke(16'h3000, 16'hF025); poke(16'h0025, 16'h5000);
        release_reset();
        run(1);
        chk("t7 R7", dut.regs_q[7], 16'h3001);
        chk("t7 pc", pc, 16'h5000);
        chk("t7 pc model", m_pc, 16'h5000);

        // Reset asserted in the middle of an LDI
        hold_reset();
        poke(16'h3000, 16'hA001); poke(16'h3002, 16'h4100);
        release_reset();
        tick(); tick(); tick();
        reset = 1'b0;
        #1;
        chk("t8 pc", pc, 16'h3000);
        chk("t8 mem_re", {15'h0, mem_re}, 16'h0);
        chk("t8 mem_we", {15'h0, mem_we}, 16'h0);
        chk("t8 mem_addr", mem_addr, 16'h0000);
        tick(); tick();
        chk("t8 no write", {15'h0, mem_we}, 16'h0);

        // Random programs over random memory
        for (int s = 0; s < 4; s++) begin
            hold_reset();
            fill_random();
            release_reset();
            run(250);
        end
        hold_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
